series_term_gen: RTL and testbench

- Upstream term generator for the series accumulator.
- Given a Q0.16 argument X, it produces the Taylor terms term_k = X^(k+1)/(k+1)! for k = 0..NTERMS-1, one after another.
- For each term it asserts a one-cycle done pulse with the term index, which the accumulator uses to choose add or subtract per MOD.
- One shared 16x16 fixed-point multiplier; recurrence term_k = term_(k-1) * X * (1/(k+1)).

---
 rtl/series_pkg.sv | 55 +++++
 rtl/fx_mul_q16.sv | 41 ++++
 rtl/series_term_gen.sv | 125 ++++++++++++
 tb/tb_series_term_gen.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/series_pkg.sv
// ============================================================================
// Module      : series_pkg
// Description : Shared constants, state encoding and reciprocal table for the
//               series term generator and its accumulator.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package series_pkg;

    localparam int W      = 16;
    localparam int NTERMS = 8;
    localparam int CW     = $clog2(NTERMS);

    // Q0.16 truncated reciprocals indexed by denominator n (1/n); entries 0 and 1 are unused.
    localparam logic [8:0][15:0] RECIP = {
        16'h2000,   // 1/8
        16'h2492,   // 1/7
        16'h2AAA,   // 1/6
        16'h3333,   // 1/5
        16'h4000,   // 1/4
        16'h5555,   // 1/3
        16'h8000,   // 1/2
        16'hFFFF,   // 1/1 (not representable)
        16'h0000    // 1/0 (undefined)
    };

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE = 3'd0;
    localparam state_t ST_LOAD = 3'd1;
    localparam state_t ST_MULX = 3'd2;
    localparam state_t ST_MULR = 3'd3;
    localparam state_t ST_EMIT = 3'd4;

    // Series selector shared with the accumulator so both sides interpret term k alike.
    typedef enum logic [1:0] {
        MOD_E   = 2'd0,
        MOD_SIN = 2'd1,
        MOD_COS = 2'd2,
        MOD_LN  = 2'd3
    } mod_t;

    function automatic logic [15:0] recip_q16(input logic [3:0] n);
        logic [15:0] r;
        r = 16'h0000;
        if (n <= 4'd8) begin
            r = RECIP[n];
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fx_mul_q16.sv
// ============================================================================
// Module      : fx_mul_q16
// Description : Combinational Q0.W x Q0.W -> Q0.W unsigned multiply.
//               Define ROUND_EN for round-half-up with saturation; otherwise
//               the product is truncated.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fx_mul_q16 #(
    parameter int W = 16
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] p
);

    logic [2*W-1:0] w_prod;

    assign w_prod = {{W{1'b0}}, a} * {{W{1'b0}}, b};

`ifdef ROUND_EN
    localparam logic [2*W:0] c_half = (2*W+1)'(1) << (W-1);

    logic [2*W:0] w_sum;
    logic         w_unused_lsb;

    assign w_sum        = {1'b0, w_prod} + c_half;
    assign w_unused_lsb = ^w_sum[W-1:0];
    // A carry into bit 2W means the rounded value reached 1.0.
    assign p = w_sum[2*W] ? {W{1'b1}} : w_sum[2*W-1:W];
`else
    logic w_unused_lsb;

    assign w_unused_lsb = ^w_prod[W-1:0];
    assign p            = w_prod[2*W-1:W];
`endif

endmodule

`default_nettype wire

// File: rtl/series_term_gen.sv
// ============================================================================
// Module      : series_term_gen
// Description : Emits Taylor terms X^(k+1)/(k+1)! for k = 0..NTERMS-1 using one
//               shared Q0.16 multiplier. ROUND_EN selects rounded multiplies.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module series_term_gen #(
    parameter int W      = 16,
    parameter int NTERMS = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [W-1:0]              Xbus,
    output logic [W-1:0]              Tbus,
    output logic                      Done,
    output logic                      co,
    output logic [$clog2(NTERMS)-1:0] count,
    output logic                      busy
);

    import series_pkg::*;

    localparam int KW = $clog2(NTERMS);

    state_t          r_state;
    logic [W-1:0]    r_xr;
    logic [W-1:0]    r_acc;
    logic [KW-1:0]   r_k;
    logic [W-1:0]    r_tbus;
    logic            r_done;
    logic            r_co;
    logic [KW-1:0]   r_count;
    logic            r_busy;

    logic [KW:0]     w_k_next;
    logic [W-1:0]    w_mul_b;
    logic [W-1:0]    w_mul;

    assign w_k_next = {1'b0, r_k} + (KW+1)'(1);

    // MULX multiplies by X; MULR (after k has advanced) multiplies by 1/(k+1).
    always_comb begin
        w_mul_b = r_xr;
        if (r_state == ST_MULR) begin
            w_mul_b = W'(recip_q16(4'(w_k_next)));
        end
    end

    fx_mul_q16 #(
        .W (W)
    ) u_mul (
        .a (r_acc),
        .b (w_mul_b),
        .p (w_mul)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_xr    <= '0;
            r_acc   <= '0;
            r_k     <= '0;
            r_tbus  <= '0;
            r_done  <= 1'b0;
            r_co    <= 1'b0;
            r_count <= '0;
            r_busy  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_co   <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    // busy lingers one cycle past the last EMIT, then drops here.
                    if (start) begin
                        r_xr    <= Xbus;
                        r_busy  <= 1'b1;
                        r_state <= ST_LOAD;
                    end else begin
                        r_busy  <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    r_acc   <= r_xr;
                    r_k     <= '0;
                    r_state <= ST_EMIT;
                end
                ST_EMIT: begin
                    r_tbus  <= r_acc;
                    r_count <= r_k;
                    r_done  <= 1'b1;
                    if (r_k == KW'(NTERMS-1)) begin
                        r_co    <= 1'b1;
                        r_state <= ST_IDLE;
                    end else begin
                        r_state <= ST_MULX;
                    end
                end
                ST_MULX: begin
                    r_acc   <= w_mul;
                    r_k     <= w_k_next[KW-1:0];
                    r_state <= ST_MULR;
                end
                ST_MULR: begin
                    r_acc   <= w_mul;
                    r_state <= ST_EMIT;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign Tbus  = r_tbus;
    assign Done  = r_done;
    assign co    = r_co;
    assign count = r_count;
    assign busy  = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_series_term_gen.sv
// ============================================================================
// Module      : tb_series_term_gen
// Description : Self-checking bench for series_term_gen against an arithmetic
//               model of the Taylor term recurrence.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_series_term_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] Xbus;
    logic [15:0] Tbus;
    logic        Done;
    logic        co;
    logic [2:0]  count;
    logic        busy;

    int total = 0;
    int bad   = 0;

    logic [15:0] exp_t [0:7];
    logic [15:0] cap   [0:7];

    typedef struct {
        logic [15:0] x;
        int          k;
        logic [15:0] t;
    } vec_t;

    vec_t vecs [0:8];

    series_term_gen dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .Xbus  (Xbus),
        .Tbus  (Tbus),
        .Done  (Done),
        .co    (co),
        .count (count),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: exact product scaled by 2^-16, rounded or truncated.
    function automatic logic [15:0] mulq(input logic [15:0] a, input logic [15:0] b);
        longint unsigned p;
        p = longint'(a) * longint'(b);
`ifdef ROUND_EN
        p = p + 64'd32768;
        if ((p >> 16) > 64'd65535) return 16'hFFFF;
`endif
        return 16'(p >> 16);
    endfunction

    task automatic compute_ref(input logic [15:0] x);
        logic [15:0] t;
        t = x;
        for (int k = 0; k < 8; k++) begin
            exp_t[k] = t;
            t = mulq(mulq(t, x), 16'(65536 / (k + 2)));
        end
    endtask

    // Call with start already driven for the E0 edge.
    task automatic run_body(input logic [15:0] x, input bit chain, input logic [15:0] nx,
                            input bit rnd, input bit poke);
        bit ed;
        int idx;
        compute_ref(x);
        for (int i = 0; i < 8; i++) cap[i] = 16'hDEAD;
        tick();
        start = 1'b0;
        for (int n = 1; n <= 23; n++) begin
            if (rnd) begin
                Xbus  = 16'($urandom);
                start = (n <= 22) ? 1'($urandom_range(0, 1)) : 1'b0;
            end
            if (poke && n == 5) begin
                start = 1'b1;
                Xbus  = 16'h1234;
            end
            if (poke && n == 6) start = 1'b0;
            if (n == 23) start = 1'b0;
            tick();
            ed = (n >= 2) && ((n - 2) % 3 == 0);
            check($sformatf("done@E%0d", n), 32'(Done), 32'(ed));
            check($sformatf("co@E%0d", n), 32'(co), 32'(ed && n == 23));
            check($sformatf("busy@E%0d", n), 32'(busy), 32'd1);
            if (Done && ed) begin
                idx = (n - 2) / 3;
                check($sformatf("count@E%0d", n), 32'(count), 32'(idx));
                check($sformatf("term%0d x=%h", idx, x), 32'(Tbus), 32'(exp_t[idx]));
                cap[idx] = Tbus;
            end
        end
        if (chain) begin
            start = 1'b1;
            Xbus  = nx;
        end else begin
            Xbus = 16'($urandom);
            tick();
            check("busy@E24", 32'(busy), 32'd0);
            check("done@E24", 32'(Done), 32'd0);
            check("hold_tbus", 32'(Tbus), 32'(exp_t[7]));
            check("hold_count", 32'(count), 32'd7);
        end
    endtask

    initial begin
        bit seen;
        logic [15:0] rx;
        logic [15:0] nx;

        vecs[0] = '{16'h8000, 0, 16'h8000};
        vecs[1] = '{16'h8000, 1, 16'h2000};
        vecs[2] = '{16'h8000, 2, 16'h0555};
        vecs[3] = '{16'hFFFF, 0, 16'hFFFF};
        vecs[4] = '{16'hFFFF, 1, 16'h7FFF};
        vecs[5] = '{16'h0000, 0, 16'h0000};
        vecs[6] = '{16'h0000, 7, 16'h0000};
        vecs[7] = '{16'hC000, 1, 16'h4800};
        vecs[8] = '{16'h4000, 1, 16'h0800};

        rst   = 1'b1;
        start = 1'b0;
        Xbus  = 16'h0;
        tick();
        tick();
        check("rst_tbus", 32'(Tbus), 32'd0);
        check("rst_done", 32'(Done), 32'd0);
        check("rst_co", 32'(co), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        tick();

        for (int v = 0; v < 9; v++) begin
            start = 1'b1;
            Xbus  = vecs[v].x;
            run_body(vecs[v].x, 1'b0, 16'h0, 1'b0, 1'b0);
            check($sformatf("vec%0d x=%h k=%0d", v, vecs[v].x, vecs[v].k),
                  32'(cap[vecs[v].k]), 32'(vecs[v].t));
            tick();
        end

        // start during a run is ignored
        start = 1'b1;
        Xbus  = 16'h8000;
        run_body(16'h8000, 1'b0, 16'h0, 1'b0, 1'b1);
        check("poke_term2", 32'(cap[2]), 32'h0555);

        // back-to-back: second start sampled at E24
        start = 1'b1;
        Xbus  = 16'h4000;
        run_body(16'h4000, 1'b1, 16'hC000, 1'b0, 1'b0);
        run_body(16'hC000, 1'b0, 16'h0, 1'b0, 1'b0);
        check("b2b_term1", 32'(cap[1]), 32'h4800);

        // mid-run reset
        start = 1'b1;
        Xbus  = 16'h8000;
        tick();
        start = 1'b0;
        for (int n = 1; n <= 6; n++) begin
            tick();
            if (n == 5) check("pre_rst_done@E5", 32'(Done), 32'd1);
        end
        rst = 1'b1;
        tick();
        check("midrst_done", 32'(Done), 32'd0);
        check("midrst_co", 32'(co), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_tbus", 32'(Tbus), 32'd0);
        check("midrst_count", 32'(count), 32'd0);
        rst  = 1'b0;
        seen = 1'b0;
        for (int n = 0; n < 30; n++) begin
            tick();
            if (Done || busy) seen = 1'b1;
        end
        check("no_activity_after_rst", 32'(seen), 32'd0);
        start = 1'b1;
        Xbus  = 16'h8000;
        run_body(16'h8000, 1'b0, 16'h0, 1'b0, 1'b0);

        // randomized runs, some chained, with start/Xbus noise mid-run
        rx = 16'($urandom);
        start = 1'b1;
        Xbus  = rx;
        for (int r = 0; r < 12; r++) begin
            nx = 16'($urandom);
            if (r == 11) begin
                run_body(rx, 1'b0, 16'h0, 1'b1, 1'b0);
            end else if ($urandom_range(0, 1) == 1) begin
                run_body(rx, 1'b1, nx, 1'b1, 1'b0);
                rx = nx;
            end else begin
                run_body(rx, 1'b0, 16'h0, 1'b1, 1'b0);
                start = 1'b1;
                rx    = nx;
                Xbus  = rx;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
